// File: rtl/tdm_demux_rx_pkg.sv
// Shared frame format for the serial TDM link: both the transmitter and
// this receiver import these constants so the two ends agree on framing.
package tdm_demux_rx_pkg;

  localparam int TDM_CH_NUM = 4;  // channels per frame
  localparam int TDM_CH_W   = 4;  // bits per channel

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_demux_rx_sipo_shift.sv
// Serial-in parallel-out shift register, MSB first.
// o_next is the value the register will hold after the current enabled
// edge, so the caller can capture a completed word on the same edge that
// shifts in its last bit. i_clr restarts the word with i_d as its first bit.
module sipo_shift #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic         i_d,
  output logic [W-1:0] o_next
);

  logic [W-1:0] r_q;
  logic [W-1:0] w_next;

  generate
    if (W == 1) begin : g_w1
      assign w_next = i_d;
    end else begin : g_wn
      assign w_next = i_clr ? {{(W-1){1'b0}}, i_d} : {r_q[W-2:0], i_d};
    end
  endgenerate

  assign o_next = w_next;

  // Shift register: advances only on enabled bit slots.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= w_next;
    end
  end

endmodule

// File: rtl/tdm_demux_rx.sv
// TDM demultiplexing receiver: rebuilds CH_NUM channels of CH_W bits from a
// sync-framed serial stream into a parallel bus that only ever shows
// complete frames (staging buffer + output register).
module tdm_demux_rx
  import tdm_demux_rx_pkg::*;
#(
  parameter int CH_NUM = TDM_CH_NUM,
  parameter int CH_W   = TDM_CH_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   bit_en,
  input  logic                   sdata,
  input  logic                   sync,
  output logic [CH_NUM*CH_W-1:0] ch_data,
  output logic                   frame_valid,
  output logic                   frame_err,
  output logic                   busy
);

  localparam int BCW = $clog2(CH_W + 1);
  localparam int CCW = $clog2(CH_NUM + 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(CH_W - 1);
  localparam logic [CCW-1:0] CH_LAST  = CCW'(CH_NUM - 1);

  state_t                  r_state;
  state_t                  w_state_next;
  logic [BCW-1:0]          r_bit_cnt;
  logic [BCW-1:0]          w_bit_cnt_inc;
  logic [CCW-1:0]          r_ch_cnt;
  logic [CCW-1:0]          w_ch_idx;
  logic                    w_start;
  logic                    w_err;
  logic                    w_bit_in;
  logic                    w_word_done;
  logic                    w_frame_done;
  logic [CH_W-1:0]         w_word;
  logic [CH_W-1:0]         r_staging [CH_NUM];
  logic [CH_NUM*CH_W-1:0]  w_frame;
  logic [CH_NUM*CH_W-1:0]  r_ch_data;
  logic                    r_frame_valid;
  logic                    r_frame_err;

  sipo_shift #(.W(CH_W)) u_sipo (
    .clk    (clk),
    .reset_n(reset_n),
    .i_en   (w_bit_in),
    .i_clr  (w_start),
    .i_d    (sdata),
    .o_next (w_word)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and per-bit control. A sync bit (from IDLE, or mid-frame as
  // an abort) is treated as bit 0 of channel 0 of a fresh frame.
  // NOTE: every signal gets a default before any branch, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_err        = 1'b0;
    w_bit_in     = 1'b0;
    if (bit_en) begin
      case (r_state)
        ST_IDLE: begin
          if (sync) begin
            w_start      = 1'b1;
            w_bit_in     = 1'b1;
            w_state_next = ST_RECV;
          end
        end
        ST_RECV: begin
          w_bit_in = 1'b1;
          if (sync) begin
            w_start = 1'b1;
            w_err   = 1'b1;
          end
        end
      endcase
    end
    w_ch_idx      = w_start ? '0 : r_ch_cnt;
    w_bit_cnt_inc = w_start ? BCW'(1) : r_bit_cnt + BCW'(1);
    w_word_done   = w_bit_in && (w_start ? (CH_W == 1) : (r_bit_cnt == BIT_LAST));
    w_frame_done  = w_word_done && (w_ch_idx == CH_LAST);
    if (w_frame_done) begin
      w_state_next = ST_IDLE;
    end
  end

  // Full frame as it will appear on completion: earlier channels from
  // staging, the last channel straight from the word finishing this edge.
  always_comb begin
    w_frame = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      w_frame[k*CH_W +: CH_W] = (k == CH_NUM - 1) ? w_word : r_staging[k];
    end
  end

  // Bit/channel counters and staging buffer; a new frame wipes staging.
  // NOTE: the staging array is reset explicitly because a mid-frame reset
  // must discard partial frames; an unreset memory would keep stale words.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bit_cnt <= '0;
      r_ch_cnt  <= '0;
      for (int k = 0; k < CH_NUM; k++) r_staging[k] <= '0;
    end else if (w_bit_in) begin
      if (w_start) begin
        for (int k = 0; k < CH_NUM; k++) r_staging[k] <= '0;
      end
      if (w_word_done) begin
        r_bit_cnt <= '0;
        r_ch_cnt  <= w_frame_done ? '0 : w_ch_idx + CCW'(1);
        for (int k = 0; k < CH_NUM; k++) begin
          if (w_ch_idx == CCW'(k)) r_staging[k] <= w_word;
        end
      end else begin
        r_bit_cnt <= w_bit_cnt_inc;
        r_ch_cnt  <= w_ch_idx;
      end
    end
  end

  // Output register and single-cycle status pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ch_data     <= '0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_frame_valid <= w_frame_done;
      r_frame_err   <= w_err;
      if (w_frame_done) begin
        r_ch_data <= w_frame;
      end
    end
  end

  assign ch_data     = r_ch_data;
  assign frame_valid = r_frame_valid;
  assign frame_err   = r_frame_err;
  assign busy        = (r_state == ST_RECV);

endmodule

// File: tb/tb_tdm_demux_rx.sv
// Directed testbench for tdm_demux_rx (CH_NUM=4, CH_W=4).
module tb_tdm_demux_rx;

  logic        clk;
  logic        reset_n;
  logic        bit_en;
  logic        sdata;
  logic        sync;
  logic [15:0] ch_data;
  logic        frame_valid;
  logic        frame_err;
  logic        busy;

  int checks;
  int errors;
  int fv_count;
  int fe_count;
  int cyc;

  tdm_demux_rx #(.CH_NUM(4), .CH_W(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bit_en     (bit_en),
    .sdata      (sdata),
    .sync       (sync),
    .ch_data    (ch_data),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sample mid-cycle; cycle counter for pulse spacing.
  always @(negedge clk) begin
    if (frame_valid) fv_count++;
    if (frame_err)   fe_count++;
  end
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // One bit slot: bit_en high for exactly one rising edge, sampled #1 after.
  task automatic send_bit(input logic s, input logic d);
    @(negedge clk);
    bit_en = 1'b1;
    sync   = s;
    sdata  = d;
    @(posedge clk);
    #1;
    bit_en = 1'b0;
    sync   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bits [first,last) of a frame; ch k = frame[4k+:4], ch0 first, MSB first.
  // 'gap' idle cycles precede each bit so the sample after the last bit is
  // taken right after its edge.
  task automatic send_bits(input logic [15:0] frame, input int first,
                           input int last, input int gap);
    for (int i = first; i < last; i++) begin
      if (gap > 0) idle(gap);
      send_bit(i == 0, frame[(i/4)*4 + (3 - i%4)]);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    bit_en  = 1'b1;
    sync    = 1'b1;
    sdata   = 1'b1;
    idle(3);
    chk("reset ch_data", ch_data, 32'h0);
    chk("reset frame_valid", frame_valid, 0);
    chk("reset frame_err", frame_err, 0);
    chk("reset busy", busy, 0);
    @(negedge clk);
    bit_en  = 1'b0;
    sync    = 1'b0;
    sdata   = 1'b0;
    reset_n = 1'b1;
    idle(2);
    chk("post-reset busy", busy, 0);
  endtask

  task automatic test_single_frame;
    int fv0;
    fv0 = fv_count;
    send_bits(16'h4321, 0, 1, 0);
    chk("single busy after sync", busy, 1);
    send_bits(16'h4321, 1, 15, 0);
    chk("single no early valid", frame_valid, 0);
    send_bits(16'h4321, 15, 16, 0);
    chk("single ch_data", ch_data, 32'h4321);
    chk("single frame_valid", frame_valid, 1);
    chk("single busy done", busy, 0);
    idle(1);
    chk("single valid self-clear", frame_valid, 0);
    idle(3);
    chk("single one pulse", fv_count - fv0, 1);
  endtask

  task automatic test_async_reset;
    send_bits(16'h5678, 0, 8, 0);
    chk("async busy mid-frame", busy, 1);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async ch_data cleared", ch_data, 32'h0);
    chk("async busy cleared", busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(2);
  endtask

  task automatic test_sparse;
    int fv0;
    fv0 = fv_count;
    send_bits(16'h4321, 0, 15, 4);
    chk("sparse busy", busy, 1);
    chk("sparse no early valid", fv_count - fv0, 0);
    idle(4);
    chk("sparse hold busy", busy, 1);
    chk("sparse hold ch_data", ch_data, 32'h0);
    send_bits(16'h4321, 15, 16, 4);
    chk("sparse ch_data", ch_data, 32'h4321);
    chk("sparse frame_valid", frame_valid, 1);
    idle(5);
    chk("sparse one pulse", fv_count - fv0, 1);
  endtask

  task automatic test_idle_ignore;
    int fv0, fe0, busy_seen;
    fv0 = fv_count;
    fe0 = fe_count;
    busy_seen = 0;
    for (int i = 0; i < 16; i++) begin
      send_bit(1'b0, 1'b1);
      if (busy) busy_seen++;
    end
    idle(2);
    chk("ignore busy never set", busy_seen, 0);
    chk("ignore ch_data kept", ch_data, 32'h4321);
    chk("ignore no valid", fv_count - fv0, 0);
    chk("ignore no err", fe_count - fe0, 0);
  endtask

  task automatic test_sync_abort;
    int fv0, fe0;
    fv0 = fv_count;
    fe0 = fe_count;
    send_bits(16'h5678, 0, 9, 0);
    send_bits(16'hDCBA, 0, 1, 0);
    chk("abort frame_err", frame_err, 1);
    chk("abort ch_data kept", ch_data, 32'h4321);
    chk("abort busy", busy, 1);
    send_bits(16'hDCBA, 1, 2, 0);
    chk("abort err self-clear", frame_err, 0);
    send_bits(16'hDCBA, 2, 16, 0);
    chk("abort new ch_data", ch_data, 32'hDCBA);
    chk("abort new valid", frame_valid, 1);
    idle(2);
    chk("abort one err", fe_count - fe0, 1);
    chk("abort one valid", fv_count - fv0, 1);
  endtask

  task automatic test_back_to_back;
    int fv0, fe0, t1, t2;
    fv0 = fv_count;
    fe0 = fe_count;
    send_bits(16'h4321, 0, 16, 0);
    chk("b2b first valid", frame_valid, 1);
    chk("b2b first ch_data", ch_data, 32'h4321);
    t1 = cyc;
    send_bits(16'h5678, 0, 16, 0);
    chk("b2b second valid", frame_valid, 1);
    chk("b2b second ch_data", ch_data, 32'h5678);
    t2 = cyc;
    chk("b2b spacing", t2 - t1, 16);
    idle(2);
    chk("b2b two pulses", fv_count - fv0, 2);
    chk("b2b no err", fe_count - fe0, 0);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    fv_count = 0;
    fe_count = 0;
    cyc      = 0;
    reset_n  = 1'b0;
    bit_en   = 1'b0;
    sync     = 1'b0;
    sdata    = 1'b0;
    test_reset;
    test_single_frame;
    test_async_reset;
    test_sparse;
    test_idle_ignore;
    test_sync_abort;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
